// File: rtl/skew_drive_queue.sv
// Queues (data, skew) writes in order and drives each onto drv_out skew+1 edges after acceptance.
// Optional flush input is enabled by defining SKEW_DRIVE_FLUSH_EN.
module skew_drive_queue #(
  parameter int                 WIDTH     = 8,
  parameter int                 DEPTH     = 8,
  parameter int                 SKEW_W    = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  localparam int                CNT_W     = $clog2(DEPTH + 1),
  localparam int                PTR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [SKEW_W-1:0] wr_skew,
  output logic [WIDTH-1:0]  drv_out,
  output logic              drv_apply,
  output logic              drv_late,
  output logic [CNT_W-1:0]  pending
`ifdef SKEW_DRIVE_FLUSH_EN
  ,
  input  logic              flush
`endif
);

  logic [WIDTH-1:0]  data_q [DEPTH];
  logic [SKEW_W-1:0] cnt_q  [DEPTH];
  logic [DEPTH-1:0]  due_q;
  logic [DEPTH-1:0]  late_q;
  logic [DEPTH-1:0]  vld_q;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              flush_now, do_pop, do_push;

`ifdef SKEW_DRIVE_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  // Full refuses writes even when the head fires on the same edge.
  assign wr_ready = (count_q != CNT_W'(DEPTH));
  assign pending  = count_q;
  assign do_pop   = !flush_now && vld_q[rd_ptr_q] && due_q[rd_ptr_q];
  assign do_push  = !flush_now && wr_valid && wr_ready;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      due_q     <= '0;
      late_q    <= '0;
      vld_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      drv_out   <= RESET_VAL;
      drv_apply <= 1'b0;
      drv_late  <= 1'b0;
    end else begin
      drv_apply <= do_pop;
      drv_late  <= do_pop && late_q[rd_ptr_q];
      if (do_pop) begin
        drv_out <= data_q[rd_ptr_q];
      end

      // Count down every queued entry; a due entry left standing becomes late.
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i]) begin
          if (cnt_q[i] != '0) begin
            cnt_q[i] <= cnt_q[i] - 1'b1;
            if (cnt_q[i] == SKEW_W'(1)) due_q[i] <= 1'b1;
          end else begin
            late_q[i] <= 1'b1;
          end
        end
      end

      if (do_pop) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= ptr_inc(rd_ptr_q);
      end

      if (do_push) begin
        data_q[wr_ptr_q] <= wr_data;
        cnt_q[wr_ptr_q]  <= wr_skew;
        due_q[wr_ptr_q]  <= (wr_skew == '0);
        late_q[wr_ptr_q] <= 1'b0;
        vld_q[wr_ptr_q]  <= 1'b1;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end

      if (flush_now) begin
        vld_q    <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule
